// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
//   Multi-cycle integer ALU for the CPU execute stage. Operands are WIDTH bits
//   wide and are processed NPC nibbles per clock, LSB first. The carry/borrow
//   between steps is held in a register. A IDLE/RUN/DONE sequencer controls the
//   work, and both sides use a valid/ready handshake.
//
//   Parameters: WIDTH (operand width, default 8), NPC (nibbles per step, default 1).
//   WIDTH must be a nonzero multiple of 4*NPC. STEPS = WIDTH/(4*NPC).
//
//   Ports:
//     clk, rst             clock; synchronous active-high reset
//     in_valid / in_ready  request handshake (in_ready only in IDLE, low during rst)
//     op_code              0 ADD,1 ADC,2 SUB,3 SBC,4 AND,5 XOR,6 OR,7 CP,8 INC,9 DEC,A DAA
//     op_a, op_b           operands
//     flags_in             {Z,N,H,C} current flags
//     out_valid/out_ready  result handshake (out_valid in DONE)
//     result, flags_out    result and next {Z,N,H,C}, held until accepted
//     busy                 high in RUN or DONE
//
//   Build option: define ALU_NIBBLE_DAA_EN to build DAA (op A). If it is not
//   defined, op A is treated like the other unsupported codes: result=op_b and
//   flags_out=flags_in.
module alu_nibble_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             busy
);

  localparam int unsigned CW    = 4 * NPC;
  localparam int unsigned STEPS = (NPC == 0) ? 1 : WIDTH / (4 * NPC);
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  if (NPC == 0 || WIDTH == 0 || (WIDTH % (4 * NPC)) != 0) begin : g_bad_cfg
    $error("alu_nibble_seq: WIDTH must be a nonzero multiple of 4*NPC");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_XOR = 4'h5, OP_OR  = 4'h6, OP_CP  = 4'h7,
    OP_INC = 4'h8, OP_DEC = 4'h9, OP_DAA = 4'hA
  } op_e;

  state_e           state, state_nxt;
  logic [SW-1:0]    step;
  logic             last;
  logic             accept;

  logic [3:0]       op_q;
  logic [3:0]       fl_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             c_q, h_q, z_q;

  logic [CW-1:0]    chunk_res, chunk_z;
  logic             carry, h_nxt, is_sub, z_fin;
  logic [3:0]       an, bn, rn, zn;
  logic [4:0]       t5;
  logic [WIDTH-1:0] res_next;
  logic [3:0]       flags_nxt;
  logic             cin_load;
  logic [WIDTH-1:0] a_load, b_load;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = in_ready && in_valid;
  assign last   = (step == LAST_STEP);
  assign is_sub = (op_q == OP_SUB) || (op_q == OP_SBC) ||
                  (op_q == OP_CP)  || (op_q == OP_DEC);

  // ---------------- Operand loading ----------------
  // INC and DEC are both done as a plain nibble add/subtract. INC uses b=0 and
  // carry-in=1. DEC uses b=1 and carry-in=0, so the carry-in rule stays the same
  // for every op.
  always_comb begin
    cin_load = 1'b0;
    a_load   = op_a;
    b_load   = op_b;
    if (op_code == OP_INC) begin
      b_load   = '0;
      cin_load = 1'b1;
    end else if (op_code == OP_DEC) begin
      b_load   = WIDTH'(1);
    end else if (op_code == OP_ADC || op_code == OP_SBC) begin
      cin_load = flags_in[0];
    end
  end

`ifdef ALU_NIBBLE_DAA_EN
  // The BCD adjust needs the whole low byte at once, so it is computed when the
  // request is accepted. The RUN steps then only stream the adjusted value and
  // build Z. The adjusted carry is stored in c_q.
  logic [7:0] daa_a, daa_corr, daa_r;
  logic       daa_c;

  always_comb begin
    daa_a    = 8'(op_a);
    daa_corr = '0;
    daa_c    = flags_in[0];
    if (!flags_in[2]) begin
      if (flags_in[0] || daa_a > 8'h99) begin
        daa_corr[7:4] = 4'h6;
        daa_c         = 1'b1;
      end
      if (flags_in[1] || daa_a[3:0] > 4'd9) daa_corr[3:0] = 4'h6;
      daa_r = daa_a + daa_corr;
    end else begin
      if (flags_in[0]) daa_corr[7:4] = 4'h6;
      if (flags_in[1]) daa_corr[3:0] = 4'h6;
      daa_r = daa_a - daa_corr;
    end
  end
`endif

  // ---------------- Nibble datapath ----------------
  always_comb begin
    carry     = c_q;
    h_nxt     = h_q;
    chunk_res = '0;
    chunk_z   = '0;
    an        = '0;
    bn        = '0;
    rn        = '0;
    zn        = '0;
    t5        = '0;
    for (int unsigned i = 0; i < NPC; i++) begin
      an = a_sh[4*i +: 4];
      bn = b_sh[4*i +: 4];
      if (is_sub) t5 = {1'b0, an} - {1'b0, bn} - {4'b0, carry};
      else        t5 = {1'b0, an} + {1'b0, bn} + {4'b0, carry};
      case (op_q)
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
          rn    = t5[3:0];
          zn    = t5[3:0];
          carry = t5[4];
          if (step == '0 && i == 0) h_nxt = t5[4];
        end
        OP_CP: begin
          rn    = an;
          zn    = t5[3:0];
          carry = t5[4];
          if (step == '0 && i == 0) h_nxt = t5[4];
        end
        OP_AND: begin rn = an & bn; zn = rn; end
        OP_XOR: begin rn = an ^ bn; zn = rn; end
        OP_OR:  begin rn = an | bn; zn = rn; end
`ifdef ALU_NIBBLE_DAA_EN
        OP_DAA: begin rn = an; zn = an; end
`endif
        default: begin rn = bn; zn = bn; end
      endcase
      chunk_res[4*i +: 4] = rn;
      chunk_z[4*i +: 4]   = zn;
    end
  end

  // The result fills in from the top. After STEPS shifts, nibble 0 is at bit 0.
  assign res_next = WIDTH'({chunk_res, res_sh} >> CW);
  assign z_fin    = !(z_q || (|chunk_z));

  always_comb begin
    flags_nxt = fl_q;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP:
        flags_nxt = {z_fin, is_sub, h_nxt, carry};
      OP_INC, OP_DEC:
        flags_nxt = {z_fin, is_sub, h_nxt, fl_q[0]};
      OP_AND:         flags_nxt = {z_fin, 3'b010};
      OP_XOR, OP_OR:  flags_nxt = {z_fin, 3'b000};
`ifdef ALU_NIBBLE_DAA_EN
      OP_DAA:         flags_nxt = {z_fin, fl_q[2], 1'b0, c_q};
`endif
      default:        flags_nxt = fl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step      <= '0;
      op_q      <= '0;
      fl_q      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c_q       <= 1'b0;
      h_q       <= 1'b0;
      z_q       <= 1'b0;
      result    <= '0;
      flags_out <= '0;
    end else if (accept) begin
      step   <= '0;
      op_q   <= op_code;
      fl_q   <= flags_in;
      a_sh   <= a_load;
      b_sh   <= b_load;
      res_sh <= '0;
      c_q    <= cin_load;
      h_q    <= 1'b0;
      z_q    <= 1'b0;
`ifdef ALU_NIBBLE_DAA_EN
      if (op_code == OP_DAA) begin
        a_sh <= WIDTH'(daa_r);
        c_q  <= daa_c;
      end
`endif
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> CW;
      b_sh   <= b_sh >> CW;
      res_sh <= res_next;
      c_q    <= carry;
      h_q    <= h_nxt;
      z_q    <= z_q || (|chunk_z);
      if (last) begin
        step      <= '0;
        result    <= res_next;
        flags_out <= flags_nxt;
      end else begin
        step <= step + SW'(1);
      end
    end
  end

endmodule
